// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of data-RAM port A.
// Registered RAM drive, fixed 2-cycle in-order responses.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q
);

  logic              ptr_q, ptr_d;
  logic              gnt0, gnt1, gnt_any, gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              s1_valid_q, s1_id_q;
  logic              resp0_valid_q, resp1_valid_q;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0_valid && (!req1_valid || !ptr_q)) gnt0 = 1'b1;
      else if (req1_valid)                       gnt1 = 1'b1;
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign gnt_id    = gnt1;
  assign ptr_d     = gnt_any ? ~gnt_id : ptr_q;
  assign sel_we    = gnt_id ? req1_we    : req0_we;
  assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      s1_valid_q    <= 1'b0;
      s1_id_q       <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      ram_we_q   <= gnt_any & sel_we;
      s1_valid_q <= gnt_any;
      s1_id_q    <= gnt_id;
      // Address/data only move on a grant; with ram_we low their value is harmless.
      if (gnt_any) begin
        ram_addr_q  <= sel_addr;
        ram_wdata_q <= sel_wdata;
      end
      resp0_valid_q <= s1_valid_q & ~s1_id_q;
      resp1_valid_q <= s1_valid_q &  s1_id_q;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_rdata = ram_q;
  assign resp1_rdata = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: behavioural RAM, queue-based reference
// model of arbitration and memory contents, directed scenarios plus random traffic.
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [DW-1:0] resp0_rdata, resp1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_q;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  // Synchronous write-first RAM, contents seeded on the first clock edge.
  logic [DW-1:0] ram [256];
  bit            ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | i;
      ram_init <= 1'b1;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      ram_q         <= ram_wdata;
    end else begin
      ram_q <= ram[ram_addr];
    end
  end

  typedef struct { bit id; logic [DW-1:0] data; int due; } exp_t;
  typedef struct { bit id; logic [DW-1:0] data; int n; }   obs_t;

  exp_t          sb[$];
  obs_t          obs[$];
  int            grant_log[$];
  logic [DW-1:0] mmem [256];
  int            mptr = 0;
  int            ncnt = 0;
  bit            exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  bit            pend_v = 1'b0, pend_id = 1'b0, pend_we = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_wdata = '0;
  int            pend_n = 0;
  bit            acc0 = 1'b0, acc1 = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic see_resp(input bit id, input logic [DW-1:0] d);
    obs_t o;
    exp_t e;
    o.id = id; o.data = d; o.n = ncnt;
    obs.push_back(o);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_resp: got resp%0d_valid=1, expected no response (t=%0t)", id, $time);
    end else begin
      e = sb.pop_front();
      check("resp_id", id, e.id);
      check("resp_rdata", d, e.data);
      check("resp_cycle", ncnt, e.due);
    end
  endtask

  // Mid-cycle: observe outputs, then decide who the rules say should win.
  task automatic monitor();
    int win;
    ncnt++;
    check("resp_onehot", resp0_valid & resp1_valid, 0);
    if (resp0_valid) see_resp(1'b0, resp0_rdata);
    if (resp1_valid) see_resp(1'b1, resp1_rdata);
    check("ram_we", ram_we, exp_we);
    check("ram_addr", ram_addr, exp_addr);
    check("ram_wdata", ram_wdata, exp_wdata);
    win = -1;
    if (en) begin
      if (req0_valid && req1_valid) win = mptr;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    check("req0_ready", req0_ready, win == 0);
    check("req1_ready", req1_ready, win == 1);
    acc0       = req0_valid && req0_ready;
    acc1       = req1_valid && req1_ready;
    pend_v     = (win >= 0);
    pend_id    = (win == 1);
    pend_we    = (win == 1) ? req1_we    : req0_we;
    pend_addr  = (win == 1) ? req1_addr  : req0_addr;
    pend_wdata = (win == 1) ? req1_wdata : req0_wdata;
    pend_n     = ncnt;
  endtask

  // Rising edge: an access granted in the previous half-cycle is taken.
  task automatic commit();
    exp_t e;
    if (pend_v) begin
      e.id  = pend_id;
      e.due = pend_n + 2;
      if (pend_we) begin
        mmem[pend_addr] = pend_wdata;
        e.data = pend_wdata;
      end else begin
        e.data = mmem[pend_addr];
      end
      sb.push_back(e);
      grant_log.push_back(int'(pend_id));
      mptr      = pend_id ? 0 : 1;
      exp_we    = pend_we;
      exp_addr  = pend_addr;
      exp_wdata = pend_wdata;
    end else begin
      exp_we = 1'b0;
    end
    pend_v = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = 32'hA500_0000 | i;
    forever begin
      @(clk or negedge rst_n);
      if (!rst_n) begin
        sb.delete();
        mptr = 0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        pend_v = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
      end else if (clk) begin
        commit();
      end else begin
        monitor();
      end
    end
  end

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int n, input bit v, input bit we = 1'b0,
                         input logic [AW-1:0] a = '0, input logic [DW-1:0] d = '0);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic idle();
    set_req(0, 1'b0);
    set_req(1, 1'b0);
  endtask

  task automatic reset_idle();
    idle();
    #1 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Accept one access, pulse reset inside the following cycle, confirm it vanishes.
  task automatic midcycle_reset(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int ob, gb;
    en = 1'b1;
    set_req(0, 1'b1, we, a, d);
    step(1);
    idle();
    ob = obs.size();
    #1 rst_n = 1'b0;
    #1;
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_resp0_valid", resp0_valid, 0);
    check("rst_resp1_valid", resp1_valid, 0);
    #1 rst_n = 1'b1;
    step(4);
    check("rst_no_resp", obs.size() - ob, 0);
    gb = grant_log.size();
    set_req(0, 1'b1, 1'b0, 8'h04);
    set_req(1, 1'b1, 1'b0, 8'h05);
    step(1);
    idle();
    step(3);
    check("rst_first_grant", grant_log[gb], 0);
  endtask

  initial begin
    int ob, gb;
    #1 rst_n = 1'b0;
    #1;
    check("init_ram_we", ram_we, 0);
    check("init_resp0_valid", resp0_valid, 0);
    check("init_resp1_valid", resp1_valid, 0);
    step(2);
    rst_n = 1'b1;

    // Single requester: write then read the same word.
    en = 1'b1;
    ob = obs.size();
    set_req(0, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
    step(1);
    set_req(0, 1'b1, 1'b0, 8'h10);
    step(1);
    idle();
    step(4);
    check("wr_rd_count", obs.size() - ob, 2);
    check("wr_rd_id0", obs[ob].id, 0);
    check("wr_rd_id1", obs[ob+1].id, 0);
    check("wr_rd_data", obs[ob+1].data, 32'hDEAD_BEEF);
    check("wr_rd_spacing", obs[ob+1].n - obs[ob].n, 1);

    // Continuous contention from reset alternates 0,1,0,...
    reset_idle();
    en = 1'b1;
    gb = grant_log.size();
    set_req(0, 1'b1, 1'b0, 8'h01);
    set_req(1, 1'b1, 1'b0, 8'h02);
    step(6);
    idle();
    step(4);
    check("rr_count", grant_log.size() - gb, 6);
    for (int i = 0; i < 6; i++) check("rr_order", grant_log[gb+i], i % 2);

    // Write from requester 1 followed at once by a read from requester 0.
    ob = obs.size();
    set_req(1, 1'b1, 1'b1, 8'hFF, 32'h0000_0005);
    step(1);
    set_req(1, 1'b0);
    set_req(0, 1'b1, 1'b0, 8'hFF);
    step(1);
    idle();
    step(4);
    check("haz_count", obs.size() - ob, 2);
    check("haz_first_id", obs[ob].id, 1);
    check("haz_second_id", obs[ob+1].id, 0);
    check("haz_data", obs[ob+1].data, 32'h0000_0005);
    check("haz_spacing", obs[ob+1].n - obs[ob].n, 1);

    // Enable gating with both requesters writing.
    reset_idle();
    en = 1'b1;
    gb = grant_log.size();
    set_req(0, 1'b1, 1'b1, 8'h30, 32'h1111_0000);
    set_req(1, 1'b1, 1'b1, 8'h31, 32'h2222_0000);
    step(1);
    en = 1'b0;
    step(3);
    check("en_off_ram_we", ram_we, 0);
    check("en_off_ready0", req0_ready, 0);
    check("en_off_ready1", req1_ready, 0);
    en = 1'b1;
    step(2);
    idle();
    step(4);
    check("en_count", grant_log.size() - gb, 3);
    check("en_grant0", grant_log[gb], 0);
    check("en_grant1", grant_log[gb+1], 1);
    check("en_grant2", grant_log[gb+2], 0);

    // Random traffic: requests held until accepted, en occasionally low.
    for (int c = 0; c < 1500; c++) begin
      if (!req0_valid || acc0)
        set_req(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 15)), $urandom);
      if (!req1_valid || acc1)
        set_req(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 15)), $urandom);
      en = ($urandom_range(0, 7) != 0);
      step(1);
    end
    idle();
    en = 1'b1;
    step(4);

    // Mid-cycle reset with a write in flight (data equals the stored value) and with a read.
    midcycle_reset(1'b1, 8'h20, mmem[8'h20]);
    midcycle_reset(1'b0, 8'h03, 32'h0);

    step(4);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
